image_scanout: RTL and testbench
================================

# image_scanout

Reads the 640x480 12-bit start-screen image ROM in raster order and drives the VGA port. Generates 640x480@60 timing from a pixel-clock enable and issues one ROM address per active pixel. Delays sync/blank to line up with ROM read latency and registers RGB and sync for the pins. Sits between the image ROM and the top-level VGA outputs, replacing the game renderer while the start screen is shown.

## Interface
- ROM_LATENCY, 1, pix_en ticks from rom_addr change to valid rom_data (0 = combinational ROM, max 2)
- H_ACTIVE/H_FP/H_SYNC/H_BP, 640/16/96/48, horizontal timing in pixels
- V_ACTIVE/V_FP/V_SYNC/V_BP, 480/10/2/33, vertical timing in lines
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  asynchronous, active-low reset
- pix_en  input  1  pixel tick; all state advances only when high
- show  input  1  1 = display image, 0 = force black
- rom_addr  output  19  linear pixel index y*640+x
- rom_data  input  12  {R[3:0],G[3:0],B[3:0]} from ROM
- vga_r, vga_g, vga_b  output  4 each  pixel colour
- vga_hs, vga_vs  output  1 each  syncs, active low
- frame_start  output  1  one-clk pulse at each frame wrap

## Operation
- h_cnt 0..799, v_cnt 0..524, advanced on pix_en. h_cnt wraps 799->0 and then increments v_cnt. v_cnt wraps 524->0 when h_cnt wraps.
- active = (h_cnt < 640) && (v_cnt < 480).
- hs_raw low for 656 <= h_cnt < 752; vs_raw low for 490 <= v_cnt < 492.
- addr_cnt register drives rom_addr directly; no multiplier:
  - +1 on pix_en while active.
  - Holds during blanking.
  - Cleared to 0 on the pix_en where counters wrap (799,524)->(0,0).
  - Invariant: addr_cnt = v_cnt*640 + h_cnt whenever active.
- Delay line of ROM_LATENCY stages carries {active, hs_raw, vs_raw}, shifting on pix_en.
- Output register, loaded on pix_en:
  - rgb = (show && active_d) ? rom_data : 12'h000.
  - vga_hs = hs_d, vga_vs = vs_d.
- frame_start: registered, high for exactly one clk, in the cycle after the pix_en that wraps counters to (0,0). No pulse out of reset.
- pix_en low: all counters, delay line and outputs hold.
- show is sampled per pixel at the output register. A mid-line change takes effect at that pixel and does not alter sync.

## Timing
- Reset values:
  - h_cnt = v_cnt = addr_cnt = 0, so rom_addr = 0.
  - Delay line = {0,1,1}.
  - vga_r/g/b = 0, vga_hs = vga_vs = 1, frame_start = 0.
- Latency: pixel (x,y) and its syncs appear at the outputs ROM_LATENCY+1 pix_en ticks after counters reach (x,y). Syncs and colour stay mutually aligned.
- Last active address 307199 (639,479). Address 307199 is never exceeded.
- Reset mid-frame: all state returns to reset values immediately (async). Scan restarts at (0,0) after rst_n deasserts, with no partial-pixel glitch on outputs.
- pix_en may be any duty cycle, including continuously high. Behaviour is identical in tick count.

## Test plan
- Reset: hold rst_n=0 with pix_en toggling -> rom_addr=0, rgb=0, vga_hs=vga_vs=1, frame_start=0 throughout; release -> rom_addr reaches 1 after first pix_en.
- Line timing, pix_en=1 always, ROM model data = addr[11:0], ROM_LATENCY=1:
  - rgb = 12'h000..12'h27F for line 0, starting 2 ticks after reset release.
  - vga_hs low for exactly 96 ticks, starting 658 ticks after line start.
  - Line period 800.
- Frame wrap: run to end of frame -> rom_addr holds 307199 through vertical blank and returns to 0 at (0,0); frame_start pulses once per 420000 ticks; vga_vs low for 1600 ticks.
- Blanking: show=0 for one full line -> rgb=0 on that line, sync timing unchanged; show toggled at x=100 -> colour changes at output pixel 100 exactly.
- Stall: pix_en=1 one cycle in 4 -> same output sequence per tick as continuous case; outputs hold between ticks.
- Reset mid-frame at (300,200): outputs and rom_addr return to reset values the same clk, with no frame_start; after release rom_addr restarts at 0.

Source files
------------

// File: rtl/image_scanout.sv
// Start-screen scan-out: 640x480@60 raster timing, linear ROM addressing and
// latency-matched, registered VGA outputs.
module image_scanout #(
    parameter int ROM_LATENCY = 1,
    parameter int H_ACTIVE    = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_ACTIVE    = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pix_en,
    input  logic        show,
    output logic [18:0] rom_addr,
    input  logic [11:0] rom_data,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic        frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_MAX  = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_MAX  = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [18:0]   ADDR_LAST = 19'(H_ACTIVE * V_ACTIVE - 1);

    function automatic logic [11:0] gate_pixel(input logic en, input logic [11:0] px);
        return en ? px : 12'h000;
    endfunction

    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic [18:0]   addr_cnt;
    logic          vld_p0, hs_p0, vs_p0;
    logic          h_wrap, frame_wrap;
    logic [2:0]    tap_p0, tap_p1;
    logic [11:0]   rgb_p2;

    // ---- stage p0: raster counters and raw timing ----
    assign vld_p0     = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    assign hs_p0      = !((h_cnt >= HS_BEG) && (h_cnt < HS_END));
    assign vs_p0      = !((v_cnt >= VS_BEG) && (v_cnt < VS_END));
    assign h_wrap     = (h_cnt == H_MAX);
    assign frame_wrap = h_wrap && (v_cnt == V_MAX);
    assign tap_p0     = {vld_p0, hs_p0, vs_p0};
    assign rom_addr   = addr_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt    <= '0;
            v_cnt    <= '0;
            addr_cnt <= '0;
        end else if (pix_en) begin
            h_cnt <= h_wrap ? '0 : h_cnt + 1'b1;
            if (h_wrap)
                v_cnt <= (v_cnt == V_MAX) ? '0 : v_cnt + 1'b1;
            // The last active pixel keeps its address through vertical blank.
            if (frame_wrap)
                addr_cnt <= '0;
            else if (vld_p0 && (addr_cnt != ADDR_LAST))
                addr_cnt <= addr_cnt + 19'd1;
        end
    end

    // ---- stage p1: timing delayed to match ROM read latency ----
    generate
        if (ROM_LATENCY == 0) begin : g_nodly
            assign tap_p1 = tap_p0;
        end else begin : g_dly
            logic [2:0] dly_p1 [ROM_LATENCY];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < ROM_LATENCY; i++)
                        dly_p1[i] <= 3'b011;
                end else if (pix_en) begin
                    dly_p1[0] <= tap_p0;
                    for (int i = 1; i < ROM_LATENCY; i++)
                        dly_p1[i] <= dly_p1[i-1];
                end
            end

            assign tap_p1 = dly_p1[ROM_LATENCY-1];
        end
    endgenerate

    // ---- stage p2: pin registers ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rgb_p2      <= 12'h000;
            vga_hs      <= 1'b1;
            vga_vs      <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            frame_start <= pix_en && frame_wrap;
            if (pix_en) begin
                rgb_p2 <= gate_pixel(show && tap_p1[2], rom_data);
                vga_hs <= tap_p1[1];
                vga_vs <= tap_p1[0];
            end
        end
    end

    assign vga_r = rgb_p2[11:8];
    assign vga_g = rgb_p2[7:4];
    assign vga_b = rgb_p2[3:0];

endmodule

// File: tb/tb_image_scanout.sv
// Directed bench for image_scanout: full-width lines with a shortened vertical
// frame so complete frames fit in a short run.
module tb_image_scanout;

    localparam int VA    = 4;
    localparam int VF    = 1;
    localparam int VS    = 2;
    localparam int VB    = 1;
    localparam int VT    = VA + VF + VS + VB;
    localparam int HT    = 800;
    localparam int FRAME = HT * VT;
    localparam int LAST  = 640 * VA - 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pix_en = 1'b0;
    logic        show = 1'b1;
    logic [18:0] rom_addr;
    logic [11:0] rom_data = 12'h000;
    logic [3:0]  vga_r, vga_g, vga_b;
    logic        vga_hs, vga_vs, frame_start;
    logic [13:0] obs;

    int vectors = 0;
    int miscompares = 0;
    int t = 0;
    bit ticked = 1'b0;

    image_scanout #(
        .ROM_LATENCY(1),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .show(show),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .vga_hs(vga_hs), .vga_vs(vga_vs), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    // Registered ROM, one pix_en tick of latency, contents = low 12 address bits.
    always @(posedge clk) if (pix_en) rom_data <= rom_addr[11:0];

    assign obs = {vga_r, vga_g, vga_b, vga_hs, vga_vs};

    // Expected {rgb, hs, vs} for output raster position n (n < 0: reset state).
    function automatic logic [13:0] exp_out(input int n, input bit shw);
        int h, v;
        logic [18:0] a;
        logic act;
        if (n < 0) return 14'h0003;
        h = n % HT;
        v = (n / HT) % VT;
        act = (h < 640) && (v < VA);
        a = 19'(v * 640 + h);
        return {(act && shw) ? a[11:0] : 12'h000,
                !((h >= 656) && (h < 752)),
                !((v >= VA + VF) && (v < VA + VF + VS))};
    endfunction

    function automatic logic [18:0] exp_addr(input int n);
        int h, v;
        h = n % HT;
        v = (n / HT) % VT;
        if ((v < VA) && (h < 640)) return 19'(v * 640 + h);
        if (v < VA - 1) return 19'((v + 1) * 640);
        return 19'(LAST);
    endfunction

    function automatic bit show_of(input int n);
        int h, v;
        if (n < 0) return 1'b1;
        h = n % HT;
        v = n / HT;
        return !(v == 1) && !((v == 2) && (h < 100));
    endfunction

    task automatic step(input logic en);
        pix_en = en;
        @(posedge clk);
        #1;
        ticked = en;
        if (en) t++;
    endtask

    task automatic do_reset();
        pix_en = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        t = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step((i % 2) == 0);
            vectors++;
            if ({rom_addr, obs, frame_start} !== {19'd0, 14'h0003, 1'b0}) begin
                miscompares++;
                $display("FAIL reset_hold cyc=%0d got addr=%0d out=%h fs=%b want addr=0 out=0003 fs=0",
                         i, rom_addr, obs, frame_start);
            end
        end
        rst_n = 1'b1;
        t = 0;
        step(1'b1);
        vectors++;
        if (rom_addr !== 19'd1) begin
            miscompares++;
            $display("FAIL reset_release_addr got %0d want 1", rom_addr);
        end
        vectors++;
        if (obs !== 14'h0003) begin
            miscompares++;
            $display("FAIL reset_release_out got %h want 0003", obs);
        end
    endtask

    task automatic test_line();
        int first_fall, second_fall, low_cnt;
        logic prev_hs;
        logic [11:0] px0, px639;
        first_fall = -1; second_fall = -1; low_cnt = 0; prev_hs = 1'b1;
        px0 = 12'hfff; px639 = 12'h000;
        do_reset();
        show = 1'b1;
        for (int k = 0; k < 1700; k++) begin
            step(1'b1);
            vectors++;
            if (obs !== exp_out(t - 2, 1'b1)) begin
                miscompares++;
                $display("FAIL line_out t=%0d got %h want %h", t, obs, exp_out(t - 2, 1'b1));
            end
            vectors++;
            if (rom_addr !== exp_addr(t)) begin
                miscompares++;
                $display("FAIL line_addr t=%0d got %0d want %0d", t, rom_addr, exp_addr(t));
            end
            if (prev_hs && !vga_hs) begin
                if (first_fall < 0) first_fall = t;
                else if (second_fall < 0) second_fall = t;
            end
            if (!vga_hs && (t < HT)) low_cnt++;
            prev_hs = vga_hs;
            if (t == 2) px0 = obs[13:2];
            if (t == 641) px639 = obs[13:2];
        end
        vectors++;
        if (first_fall != 658) begin
            miscompares++;
            $display("FAIL hs_start got %0d want 658", first_fall);
        end
        vectors++;
        if (second_fall != 1458) begin
            miscompares++;
            $display("FAIL line_period got %0d want 1458", second_fall);
        end
        vectors++;
        if (low_cnt != 96) begin
            miscompares++;
            $display("FAIL hs_width got %0d want 96", low_cnt);
        end
        vectors++;
        if ((px0 !== 12'h000) || (px639 !== 12'h27f)) begin
            miscompares++;
            $display("FAIL line0_ends got %h/%h want 000/27f", px0, px639);
        end
    endtask

    task automatic test_frame();
        int pulses, vs_low;
        logic [18:0] addr_end, addr_wrap;
        pulses = 0; vs_low = 0; addr_end = '0; addr_wrap = '1;
        do_reset();
        show = 1'b1;
        for (int k = 0; k < FRAME + 900; k++) begin
            step(1'b1);
            vectors++;
            if (obs !== exp_out(t - 2, 1'b1)) begin
                miscompares++;
                $display("FAIL frame_out t=%0d got %h want %h", t, obs, exp_out(t - 2, 1'b1));
            end
            vectors++;
            if (rom_addr !== exp_addr(t)) begin
                miscompares++;
                $display("FAIL frame_addr t=%0d got %0d want %0d", t, rom_addr, exp_addr(t));
            end
            vectors++;
            if (frame_start !== ((t % FRAME) == 0)) begin
                miscompares++;
                $display("FAIL frame_start t=%0d got %b want %b", t, frame_start, (t % FRAME) == 0);
            end
            if (frame_start) pulses++;
            if (!vga_vs) vs_low++;
            if (t == FRAME - 1) addr_end = rom_addr;
            if (t == FRAME) addr_wrap = rom_addr;
        end
        vectors++;
        if (pulses != 1) begin
            miscompares++;
            $display("FAIL frame_pulses got %0d want 1", pulses);
        end
        vectors++;
        if (vs_low != 1600) begin
            miscompares++;
            $display("FAIL vs_width got %0d want 1600", vs_low);
        end
        vectors++;
        if ((addr_end !== 19'd2559) || (addr_wrap !== 19'd0)) begin
            miscompares++;
            $display("FAIL addr_wrap got %0d/%0d want 2559/0", addr_end, addr_wrap);
        end
    endtask

    task automatic test_blank();
        logic [11:0] px99, px100;
        px99 = 12'hfff; px100 = 12'h000;
        do_reset();
        for (int k = 0; k < 2600; k++) begin
            show = show_of(t + 1 - 2);
            step(1'b1);
            vectors++;
            if (obs !== exp_out(t - 2, show_of(t - 2))) begin
                miscompares++;
                $display("FAIL blank_out t=%0d got %h want %h", t, obs, exp_out(t - 2, show_of(t - 2)));
            end
            if (t - 2 == 2 * HT + 99) px99 = obs[13:2];
            if (t - 2 == 2 * HT + 100) px100 = obs[13:2];
        end
        vectors++;
        if ((px99 !== 12'h000) || (px100 !== 12'h564)) begin
            miscompares++;
            $display("FAIL show_toggle got %h/%h want 000/564", px99, px100);
        end
        show = 1'b1;
    endtask

    task automatic test_stall();
        int pulses;
        pulses = 0;
        do_reset();
        show = 1'b1;
        for (int c = 0; c < (FRAME + 200) * 4; c++) begin
            step((c % 4) == 0);
            vectors++;
            if (obs !== exp_out(t - 2, 1'b1)) begin
                miscompares++;
                $display("FAIL stall_out c=%0d t=%0d got %h want %h", c, t, obs, exp_out(t - 2, 1'b1));
            end
            vectors++;
            if (rom_addr !== exp_addr(t)) begin
                miscompares++;
                $display("FAIL stall_addr c=%0d got %0d want %0d", c, rom_addr, exp_addr(t));
            end
            vectors++;
            if (frame_start !== (ticked && ((t % FRAME) == 0))) begin
                miscompares++;
                $display("FAIL stall_fs c=%0d got %b want %b", c, frame_start, ticked && ((t % FRAME) == 0));
            end
            if (frame_start) pulses++;
        end
        vectors++;
        if (pulses != 1) begin
            miscompares++;
            $display("FAIL stall_pulses got %0d want 1", pulses);
        end
    endtask

    task automatic test_midreset();
        do_reset();
        show = 1'b1;
        while (t < 2 * HT + 300) begin
            step(1'b1);
            vectors++;
            if (obs !== exp_out(t - 2, 1'b1)) begin
                miscompares++;
                $display("FAIL pre_reset_out t=%0d got %h want %h", t, obs, exp_out(t - 2, 1'b1));
            end
        end
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({rom_addr, obs, frame_start} !== {19'd0, 14'h0003, 1'b0}) begin
            miscompares++;
            $display("FAIL async_reset got addr=%0d out=%h fs=%b want addr=0 out=0003 fs=0",
                     rom_addr, obs, frame_start);
        end
        for (int i = 0; i < 4; i++) begin
            step(1'b1);
            vectors++;
            if ({rom_addr, obs, frame_start} !== {19'd0, 14'h0003, 1'b0}) begin
                miscompares++;
                $display("FAIL reset_held cyc=%0d got addr=%0d out=%h fs=%b", i, rom_addr, obs, frame_start);
            end
        end
        rst_n = 1'b1;
        t = 0;
        for (int i = 0; i < 10; i++) begin
            step(1'b1);
            vectors++;
            if ({rom_addr, obs, frame_start} !== {exp_addr(t), exp_out(t - 2, 1'b1), 1'b0}) begin
                miscompares++;
                $display("FAIL restart t=%0d got addr=%0d out=%h fs=%b want addr=%0d out=%h fs=0",
                         t, rom_addr, obs, frame_start, exp_addr(t), exp_out(t - 2, 1'b1));
            end
        end
    endtask

    initial begin
        test_reset();
        test_line();
        test_frame();
        test_blank();
        test_stall();
        test_midreset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
